// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART TX byte stream among NREQ requesters.
// A grant lasts a whole message: released on tlast, a burst-length cap, or an idle timeout.
module uart_tx_arbiter #(
    parameter  int NREQ         = 4,
    parameter  int DLEN         = 8,
    parameter  int MAX_BURST    = 16,
    parameter  int IDLE_TIMEOUT = 64,
    localparam int IW           = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW           = $clog2(MAX_BURST + 1),
    localparam int TW           = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_tvalid,
    output logic [NREQ-1:0]      o_tready,
    input  logic [NREQ*DLEN-1:0] i_tdata,
    input  logic [NREQ-1:0]      i_tlast,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic [DLEN-1:0]      o_tdata,
    output logic [IW-1:0]        o_tid,
    output logic                 o_busy
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;
    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_grant, r_rr_ptr, w_grant_nxt, w_rr_nxt, w_pick, w_inc;
    logic [BW-1:0]   r_beat_cnt, w_beat_nxt;
    logic [TW-1:0]   r_idle_cnt, w_idle_nxt;
    logic [NREQ-1:0] w_sel;
    logic [DLEN-1:0] w_lane;
    logic            w_busy, w_live, w_gvalid, w_glast, w_xfer, w_release;

    // Descending scan so the requester closest to r_rr_ptr (wrapping) wins.
    always_comb begin
        logic [IW:0] s;
        w_pick = r_rr_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            s = {1'b0, r_rr_ptr} + (IW+1)'(i);
            s = (s >= (IW+1)'(NREQ)) ? s - (IW+1)'(NREQ) : s;
            if (i_tvalid[s[IW-1:0]]) w_pick = s[IW-1:0];
        end
    end

    always_comb begin
        w_sel    = '0;
        w_lane   = '0;
        w_gvalid = 1'b0;
        w_glast  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant == IW'(k)) begin
                w_sel[k] = 1'b1;
                w_lane   = i_tdata[k*DLEN +: DLEN];
                w_gvalid = i_tvalid[k];
                w_glast  = i_tlast[k];
            end
        end
    end

    // Outputs are gated by rst so a reset cycle never completes a transfer.
    assign w_busy    = r_state == S_GRANT;
    assign w_live    = w_busy && !rst;
    assign o_tvalid  = w_live && w_gvalid;
    assign o_tdata   = w_live ? w_lane : '0;
    assign o_tready  = (w_live && i_tready) ? w_sel : '0;
    assign o_tid     = r_grant;
    assign o_busy    = w_busy;
    assign w_xfer    = o_tvalid && i_tready;
    assign w_release = (w_xfer && (w_glast || r_beat_cnt == BW'(MAX_BURST - 1))) ||
                       (!w_gvalid && r_idle_cnt == TW'(IDLE_TIMEOUT - 1));
    assign w_inc     = (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_idle_nxt  = r_idle_cnt;
        if (!w_busy) begin
            if (|i_tvalid) begin
                w_state_nxt = S_GRANT;
                w_grant_nxt = w_pick;
                w_beat_nxt  = '0;
                w_idle_nxt  = '0;
            end
        end else begin
            w_beat_nxt  = w_xfer ? r_beat_cnt + 1'b1 : r_beat_cnt;
            w_idle_nxt  = w_xfer ? '0 : (!w_gvalid ? r_idle_cnt + 1'b1 : r_idle_cnt);
            w_state_nxt = w_release ? S_IDLE : S_GRANT;
            w_rr_nxt    = w_release ? w_inc : r_rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter with simple AXI-stream byte sources.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i_tvalid = '0;
    logic [3:0]  o_tready;
    logic [31:0] i_tdata = '0;
    logic [3:0]  i_tlast = '0;
    logic        o_tvalid;
    logic        i_tready = 1'b1;
    logic [7:0]  o_tdata;
    logic [1:0]  o_tid;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int src_rem[4];
    int src_beat[4];
    bit src_off[4];
    bit tb_rst   = 1'b1;
    bit tb_ready = 1'b1;
    logic       obs_busy, obs_tvalid, obs_xfer;
    logic [1:0] obs_tid;
    logic [7:0] obs_tdata;
    logic [3:0] obs_tready;
    int log_tid[$];
    int log_data[$];
    int log_cyc[$];

    uart_tx_arbiter #(.NREQ(4), .DLEN(8), .MAX_BURST(16), .IDLE_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .i_tvalid(i_tvalid), .o_tready(o_tready), .i_tdata(i_tdata),
        .i_tlast(i_tlast), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tdata(o_tdata),
        .o_tid(o_tid), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1);
    end

    // Source k sends bytes {k, beat}; tlast on the final beat of its current message.
    task automatic cyc();
        @(negedge clk);
        rst      = tb_rst;
        i_tready = tb_ready;
        for (int k = 0; k < 4; k++) begin
            i_tvalid[k]       = (src_rem[k] > 0) && !src_off[k];
            i_tlast[k]        = src_rem[k] == 1;
            i_tdata[k*8 +: 8] = 8'(k * 64 + src_beat[k]);
        end
        #1;
        obs_busy   = o_busy;
        obs_tvalid = o_tvalid;
        obs_tid    = o_tid;
        obs_tdata  = o_tdata;
        obs_tready = o_tready;
        obs_xfer   = o_tvalid && i_tready;
        if (obs_xfer) begin
            log_tid.push_back(int'(o_tid));
            log_data.push_back(int'(o_tdata));
            log_cyc.push_back(cyc_n);
        end
        for (int k = 0; k < 4; k++) begin
            if (o_tready[k] && i_tvalid[k]) begin
                src_rem[k]--;
                src_beat[k]++;
            end
        end
        cyc_n++;
    endtask

    task automatic do_reset();
        for (int k = 0; k < 4; k++) begin
            src_rem[k]  = 0;
            src_beat[k] = 0;
            src_off[k]  = 1'b0;
        end
        log_tid.delete();
        log_data.delete();
        log_cyc.delete();
        tb_ready = 1'b1;
        tb_rst   = 1'b1;
        cyc();
        cyc();
        tb_rst = 1'b0;
    endtask

    task automatic test_reset();
        tb_rst = 1'b1;
        for (int k = 0; k < 4; k++) src_rem[k] = 1;
        repeat (3) begin
            cyc();
            checks++;
            if ({obs_busy, obs_tvalid, obs_tready, obs_tdata, obs_tid} !== 16'h0) begin
                errors++;
                $display("FAIL reset_outputs got %h want 0000", {obs_busy, obs_tvalid, obs_tready, obs_tdata, obs_tid});
            end
        end
        tb_rst = 1'b0;
        cyc();
        checks++;
        if ({obs_busy, obs_tready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_first_idle got %b want 00000", {obs_busy, obs_tready});
        end
        cyc();
        checks++;
        if ({obs_busy, obs_tid, obs_tready, obs_xfer, obs_tdata} !== {1'b1, 2'd0, 4'b0001, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL reset_first_grant got %h want %h", {obs_busy, obs_tid, obs_tready, obs_xfer, obs_tdata},
                     {1'b1, 2'd0, 4'b0001, 1'b1, 8'h00});
        end
        cyc();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_gap_idle got %b want 0", obs_busy);
        end
        cyc();
        checks++;
        if ({obs_busy, obs_tid} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL reset_next_grant got %b want 101", {obs_busy, obs_tid});
        end
    endtask

    task automatic test_round_robin();
        bit reloaded = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) src_rem[k] = 2;
        for (int n = 0; n < 60 && log_tid.size() < 10; n++) begin
            cyc();
            if (!reloaded && src_rem[0] == 0) begin
                src_rem[0] = 2;
                reloaded   = 1'b1;
            end
        end
        checks++;
        if (log_tid.size() != 10) begin
            errors++;
            $display("FAIL rr_count got %0d want 10", log_tid.size());
        end
        for (int j = 0; j < 10 && j < log_tid.size(); j++) begin
            int et = (j < 8) ? j / 2 : 0;
            int ed = (j < 8) ? (j / 2) * 64 + j % 2 : j - 6;
            checks++;
            if (log_tid[j] != et || log_data[j] != ed) begin
                errors++;
                $display("FAIL rr_beat%0d got tid %0d data %h want tid %0d data %h", j, log_tid[j], log_data[j], et, ed);
            end
            checks++;
            if (log_cyc[j] - log_cyc[0] != j + j / 2) begin
                errors++;
                $display("FAIL rr_timing%0d got offset %0d want %0d", j, log_cyc[j] - log_cyc[0], j + j / 2);
            end
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        src_rem[1] = 40;
        src_rem[2] = 3;
        for (int n = 0; n < 120 && log_tid.size() < 43; n++) cyc();
        checks++;
        if (log_tid.size() != 43) begin
            errors++;
            $display("FAIL burst_count got %0d want 43", log_tid.size());
        end
        for (int j = 0; j < 43 && j < log_tid.size(); j++) begin
            int et = (j >= 16 && j < 19) ? 2 : 1;
            int ed = (j < 16) ? 64 + j : (j < 19) ? 128 + j - 16 : 64 + j - 3;
            checks++;
            if (log_tid[j] != et || log_data[j] != ed) begin
                errors++;
                $display("FAIL burst_beat%0d got tid %0d data %h want tid %0d data %h", j, log_tid[j], log_data[j], et, ed);
            end
        end
        if (log_cyc.size() == 43) begin
            checks++;
            if (log_cyc[16] - log_cyc[15] != 2 || log_cyc[19] - log_cyc[18] != 2 || log_cyc[35] - log_cyc[34] != 2) begin
                errors++;
                $display("FAIL burst_gaps got %0d %0d %0d want 2 2 2", log_cyc[16] - log_cyc[15],
                         log_cyc[19] - log_cyc[18], log_cyc[35] - log_cyc[34]);
            end
        end
    endtask

    task automatic test_timeout();
        int held = 0;
        do_reset();
        src_rem[0] = 2;
        src_rem[3] = 1;
        cyc();
        cyc();
        checks++;
        if (log_tid.size() != 1) begin
            errors++;
            $display("FAIL timeout_first_beat got %0d beats want 1", log_tid.size());
        end
        src_off[0] = 1'b1;
        repeat (64) begin
            cyc();
            held += (obs_busy === 1'b1 && obs_tid === 2'd0) ? 1 : 0;
        end
        checks++;
        if (held != 64) begin
            errors++;
            $display("FAIL timeout_hold got %0d cycles want 64", held);
        end
        cyc();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release got busy %b want 0", obs_busy);
        end
        cyc();
        checks++;
        if ({obs_busy, obs_tid, obs_xfer, obs_tdata} !== {1'b1, 2'd3, 1'b1, 8'hC0}) begin
            errors++;
            $display("FAIL timeout_next got %h want %h", {obs_busy, obs_tid, obs_xfer, obs_tdata}, {1'b1, 2'd3, 1'b1, 8'hC0});
        end
        do_reset();
        src_rem[0] = 2;
        src_rem[3] = 1;
        cyc();
        cyc();
        src_off[0] = 1'b1;
        held = 0;
        repeat (63) begin
            cyc();
            held += (obs_busy === 1'b1 && obs_tid === 2'd0) ? 1 : 0;
        end
        checks++;
        if (held != 63) begin
            errors++;
            $display("FAIL timeout63_hold got %0d cycles want 63", held);
        end
        src_off[0] = 1'b0;
        cyc();
        checks++;
        if ({obs_busy, obs_tid, obs_xfer, obs_tdata} !== {1'b1, 2'd0, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL timeout63_resume got %h want %h", {obs_busy, obs_tid, obs_xfer, obs_tdata}, {1'b1, 2'd0, 1'b1, 8'h01});
        end
        cyc();
        cyc();
        checks++;
        if ({obs_busy, obs_tid} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL timeout63_next got %b want 111", {obs_busy, obs_tid});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        tb_ready   = 1'b0;
        src_rem[2] = 3;
        cyc();
        repeat (200) begin
            cyc();
            checks++;
            if ({obs_busy, obs_tid, obs_tvalid, obs_tdata, obs_tready} !== {1'b1, 2'd2, 1'b1, 8'h80, 4'b0000}) begin
                errors++;
                $display("FAIL bp_stall cycle %0d got %h want %h", cyc_n, {obs_busy, obs_tid, obs_tvalid, obs_tdata, obs_tready},
                         {1'b1, 2'd2, 1'b1, 8'h80, 4'b0000});
            end
        end
        tb_ready = 1'b1;
        cyc();
        checks++;
        if (obs_tready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_ready got %b want 0100", obs_tready);
        end
        cyc();
        cyc();
        checks++;
        if (log_data.size() != 3 || log_data[0] != 'h80 || log_data[1] != 'h81 || log_data[2] != 'h82) begin
            errors++;
            $display("FAIL bp_order got %0d beats first %h want 3 beats 80 81 82", log_data.size(),
                     (log_data.size() > 0) ? log_data[0] : 0);
        end
        cyc();
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got busy %b want 0", obs_busy);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        src_rem[0] = 1;
        src_rem[1] = 5;
        for (int n = 0; n < 20 && log_tid.size() < 3; n++) cyc();
        checks++;
        if (log_tid.size() != 3 || log_tid[2] != 1) begin
            errors++;
            $display("FAIL mid_setup got %0d beats want 3 ending on req1", log_tid.size());
        end
        src_rem[0] = 1;
        tb_rst     = 1'b1;
        cyc();
        checks++;
        if ({obs_tready, obs_tvalid} !== 5'b0 || log_tid.size() != 3) begin
            errors++;
            $display("FAIL mid_drop got tready %b tvalid %b beats %0d want 0000 0 3", obs_tready, obs_tvalid, log_tid.size());
        end
        tb_rst = 1'b0;
        cyc();
        checks++;
        if ({obs_busy, obs_tid} !== 3'b000) begin
            errors++;
            $display("FAIL mid_idle got %b want 000", {obs_busy, obs_tid});
        end
        cyc();
        checks++;
        if ({obs_busy, obs_tid, obs_xfer, obs_tdata} !== {1'b1, 2'd0, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL mid_req0_wins got %h want %h", {obs_busy, obs_tid, obs_xfer, obs_tdata}, {1'b1, 2'd0, 1'b1, 8'h01});
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_timeout();
        test_backpressure();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
